// File: rtl/cache_fill_ctrl_if.sv
// rtl/cache_fill_ctrl_if.sv - AXI read-data channel bundle feeding the cache fill controller
// Signals:
//   rvalid, rdata[DW], rresp[2], rlast : driven by the AXI source (master)
//   rready                             : driven by the fill controller (slave)
interface cache_fill_ctrl_if #(
  parameter int DW = 64
);
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rready;

  modport master (output rvalid, rdata, rresp, rlast, input rready);
  modport slave  (input rvalid, rdata, rresp, rlast, output rready);
endinterface

// File: rtl/cache_fill_ctrl.sv
// rtl/cache_fill_ctrl.sv - fills one of two ping-pong caches from an AXI read burst
// Ports:
//   clock, resetn (async, active-low)
//   start/beats/lastBytes : burst fill request, beat count and valid bytes of final beat
//   abort                 : synchronous cancel back to IDLE
//   drainEmpty            : the other cache is empty, so the caches may swap
//   axi (slave)           : AXI R channel (rvalid, rdata, rresp, rlast in; rready out)
//   wrEn/wrAddr/wrData/wrByteCnt : registered cache write port
//   fillSel               : cache currently being filled
//   busy, fillDone, respErr, lastErr, cfgErr : status
module cache_fill_ctrl #(
  parameter int CACHE_WIDTH = 8,
  parameter int CACHE_DEPTH = 16,
  localparam int DW = CACHE_WIDTH * 8,
  localparam int AW = ($clog2(CACHE_DEPTH - 1) > 0) ? $clog2(CACHE_DEPTH - 1) : 1,
  localparam int BW = $clog2(CACHE_DEPTH) + 1,
  localparam int CW = $clog2(CACHE_WIDTH) + 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [BW-1:0]    beats,
  input  logic [CW-1:0]    lastBytes,
  input  logic             abort,
  input  logic             drainEmpty,
  cache_fill_ctrl_if.slave axi,
  output logic             wrEn,
  output logic [AW-1:0]    wrAddr,
  output logic [DW-1:0]    wrData,
  output logic [CW-1:0]    wrByteCnt,
  output logic             fillSel,
  output logic             busy,
  output logic             fillDone,
  output logic             respErr,
  output logic             lastErr,
  output logic             cfgErr
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, SWAP = 2'd2} state_t;

  state_t        state;
  state_t        state_next;
  logic [BW-1:0] beats_q;
  logic [CW-1:0] last_bytes_q;
  logic [AW-1:0] addr;
  logic [BW-1:0] beat_cnt;

  logic beats_ok;
  logic hs;
  logic final_beat;
  logic burst_end;

  assign beats_ok   = (beats != '0) && (beats <= BW'(CACHE_DEPTH));
  assign hs         = axi.rvalid & axi.rready;
  // beat_cnt counts beats already accepted, so the final beat is the one
  // arriving when beats_q-1 have been taken.
  assign final_beat = (beat_cnt == beats_q - BW'(1));
  // An early rlast terminates the burst just like the final counted beat.
  assign burst_end  = hs & (final_beat | axi.rlast);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start && beats_ok) state_next = FILL;
        FILL:    if (burst_end) state_next = SWAP;
        SWAP:    if (drainEmpty) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // rready depends on state only, so a beat offered in the abort cycle is
  // still accepted and written.
  always_comb begin
    axi.rready = 1'b0;
    busy       = 1'b0;
    case (state)
      FILL: begin
        axi.rready = 1'b1;
        busy       = 1'b1;
      end
      SWAP:    busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      beats_q      <= '0;
      last_bytes_q <= '0;
      addr         <= '0;
      beat_cnt     <= '0;
      wrEn         <= 1'b0;
      wrAddr       <= '0;
      wrData       <= '0;
      wrByteCnt    <= '0;
      fillSel      <= 1'b0;
      fillDone     <= 1'b0;
      respErr      <= 1'b0;
      lastErr      <= 1'b0;
      cfgErr       <= 1'b0;
    end else begin
      wrEn     <= 1'b0;
      fillDone <= 1'b0;
      cfgErr   <= 1'b0;

      if (state == IDLE && start && !abort) begin
        if (beats_ok) begin
          beats_q      <= beats;
          last_bytes_q <= lastBytes;
          addr         <= '0;
          beat_cnt     <= '0;
          respErr      <= 1'b0;
          lastErr      <= 1'b0;
        end else begin
          cfgErr <= 1'b1;
        end
      end

      if (hs) begin
        wrEn   <= 1'b1;
        wrAddr <= addr;
        wrData <= axi.rdata;
        if (final_beat) begin
          wrByteCnt <= (last_bytes_q == '0) ? CW'(CACHE_WIDTH) : last_bytes_q;
        end else begin
          wrByteCnt <= CW'(CACHE_WIDTH);
        end
        if (addr != AW'(CACHE_DEPTH - 1)) addr <= addr + AW'(1);
        if (beat_cnt != BW'(CACHE_DEPTH)) beat_cnt <= beat_cnt + BW'(1);
        if (axi.rresp != 2'd0) respErr <= 1'b1;
        // Mismatch in either direction: rlast missing on the final beat or
        // arriving before it.
        if (final_beat != axi.rlast) lastErr <= 1'b1;
      end

      if (state == FILL && burst_end && !abort) fillDone <= 1'b1;

      if (state == SWAP && drainEmpty && !abort) fillSel <= ~fillSel;
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb/tb_cache_fill_ctrl.sv - self-checking bench for cache_fill_ctrl against a behavioural model
// Ports: none (drives clock, resetn, control inputs and the AXI R channel interface).
module tb_cache_fill_ctrl;
  localparam int CACHE_WIDTH = 8;
  localparam int CACHE_DEPTH = 16;
  localparam int DW = CACHE_WIDTH * 8;
  localparam int AW = 4;
  localparam int BW = 5;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [BW-1:0] beats = '0;
  logic [CW-1:0] lastBytes = '0;
  logic          abort = 1'b0;
  logic          drainEmpty = 1'b0;
  logic          wrEn;
  logic [AW-1:0] wrAddr;
  logic [DW-1:0] wrData;
  logic [CW-1:0] wrByteCnt;
  logic          fillSel;
  logic          busy;
  logic          fillDone;
  logic          respErr;
  logic          lastErr;
  logic          cfgErr;

  cache_fill_ctrl_if #(.DW(DW)) axi ();

  cache_fill_ctrl #(.CACHE_WIDTH(CACHE_WIDTH), .CACHE_DEPTH(CACHE_DEPTH)) dut (
    .clock(clock), .resetn(resetn), .start(start), .beats(beats), .lastBytes(lastBytes),
    .abort(abort), .drainEmpty(drainEmpty), .axi(axi), .wrEn(wrEn), .wrAddr(wrAddr),
    .wrData(wrData), .wrByteCnt(wrByteCnt), .fillSel(fillSel), .busy(busy),
    .fillDone(fillDone), .respErr(respErr), .lastErr(lastErr), .cfgErr(cfgErr)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Behavioural model: phase 0=idle, 1=filling, 2=waiting to swap.
  int            m_state, m_beats, m_lastb, m_taken;
  bit            m_fillSel, m_respErr, m_lastErr;
  bit            e_wrEn, e_fillDone, e_cfgErr;
  int            e_wrAddr, e_wrByteCnt;
  logic [DW-1:0] e_wrData;

  int dut_addr[$];
  int dut_bytes[$];
  int dut_fd = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_beats = 0; m_lastb = 0; m_taken = 0;
    m_fillSel = 0; m_respErr = 0; m_lastErr = 0;
    e_wrEn = 0; e_fillDone = 0; e_cfgErr = 0;
    e_wrAddr = 0; e_wrByteCnt = 0; e_wrData = '0;
  endtask

  // Applies one clock edge of the rules to the inputs present at that edge.
  task automatic model_step();
    int nxt;
    bit hs, fin, lst;
    if (!resetn) begin
      model_reset();
      return;
    end
    e_wrEn = 0; e_fillDone = 0; e_cfgErr = 0;
    nxt = m_state;
    hs = (m_state == 1) && (axi.rvalid == 1'b1);
    if (hs) begin
      fin = (m_taken + 1 == m_beats);
      lst = axi.rlast;
      e_wrEn = 1;
      e_wrAddr = m_taken;
      e_wrData = axi.rdata;
      e_wrByteCnt = fin ? ((m_lastb == 0) ? CACHE_WIDTH : m_lastb) : CACHE_WIDTH;
      if (axi.rresp != 2'd0) m_respErr = 1;
      if (fin != lst) m_lastErr = 1;
      m_taken++;
      if ((fin || lst) && !abort) begin
        nxt = 2;
        e_fillDone = 1;
      end
    end
    if (abort) begin
      nxt = 0;
    end else if (m_state == 0 && start) begin
      if (int'(beats) >= 1 && int'(beats) <= CACHE_DEPTH) begin
        m_beats = int'(beats);
        m_lastb = int'(lastBytes);
        m_taken = 0;
        m_respErr = 0;
        m_lastErr = 0;
        nxt = 1;
      end else begin
        e_cfgErr = 1;
      end
    end else if (m_state == 2 && drainEmpty) begin
      m_fillSel = !m_fillSel;
      nxt = 0;
    end
    m_state = nxt;
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("rready", 64'(axi.rready), 64'(m_state == 1));
      chk("busy", 64'(busy), 64'(m_state != 0));
      chk("wrEn", 64'(wrEn), 64'(e_wrEn));
      if (e_wrEn) begin
        chk("wrAddr", 64'(wrAddr), 64'(e_wrAddr));
        chk("wrData", 64'(wrData), 64'(e_wrData));
        chk("wrByteCnt", 64'(wrByteCnt), 64'(e_wrByteCnt));
      end
      chk("fillSel", 64'(fillSel), 64'(m_fillSel));
      chk("fillDone", 64'(fillDone), 64'(e_fillDone));
      chk("cfgErr", 64'(cfgErr), 64'(e_cfgErr));
      if (m_state == 2) begin
        chk("respErr", 64'(respErr), 64'(m_respErr));
        chk("lastErr", 64'(lastErr), 64'(m_lastErr));
      end
      if (wrEn) begin
        dut_addr.push_back(int'(wrAddr));
        dut_bytes.push_back(int'(wrByteCnt));
      end
      if (fillDone) dut_fd++;
    end
  end

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic do_start(input int b, input int lb);
    start = 1'b1;
    beats = BW'(b);
    lastBytes = CW'(lb);
    tick();
    start = 1'b0;
  endtask

  task automatic run_burst(input int rlast_at, input int err_at, input bit gaps);
    int guard = 0;
    while (m_state == 1 && guard < 200) begin
      axi.rvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      axi.rdata  = {$urandom, $urandom};
      axi.rlast  = (m_taken + 1 == rlast_at);
      axi.rresp  = (m_taken + 1 == err_at) ? 2'd2 : 2'd0;
      tick();
      guard++;
    end
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    axi.rresp  = 2'd0;
  endtask

  task automatic do_swap(input int stall);
    drainEmpty = 1'b0;
    repeat (stall) tick();
    drainEmpty = 1'b1;
    tick();
    drainEmpty = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rready"}, 64'(axi.rready), 64'(0));
    chk({tag, "_wrEn"}, 64'(wrEn), 64'(0));
    chk({tag, "_wrAddr"}, 64'(wrAddr), 64'(0));
    chk({tag, "_wrData"}, 64'(wrData), 64'(0));
    chk({tag, "_wrByteCnt"}, 64'(wrByteCnt), 64'(0));
    chk({tag, "_fillSel"}, 64'(fillSel), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_fillDone"}, 64'(fillDone), 64'(0));
    chk({tag, "_respErr"}, 64'(respErr), 64'(0));
    chk({tag, "_lastErr"}, 64'(lastErr), 64'(0));
    chk({tag, "_cfgErr"}, 64'(cfgErr), 64'(0));
  endtask

  initial begin
    int fd0;
    int guard;
    int exp_b[4] = '{8, 8, 8, 3};

    axi.rvalid = 1'b0;
    axi.rdata  = '0;
    axi.rresp  = 2'd0;
    axi.rlast  = 1'b0;
    model_reset();
    tick();
    tick();
    check_reset_vals("rst");
    resetn = 1'b1;
    chk_en = 1'b1;
    tick();

    // Full burst: 4 back-to-back beats, 3 bytes in the last one.
    dut_addr.delete(); dut_bytes.delete(); fd0 = dut_fd;
    drainEmpty = 1'b1;
    do_start(4, 3);
    run_burst(4, 0, 1'b0);
    do_swap(0);
    chk("t1_nwr", 64'(dut_addr.size()), 64'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < dut_addr.size()) begin
        chk("t1_addr", 64'(dut_addr[i]), 64'(i));
        chk("t1_bytes", 64'(dut_bytes[i]), 64'(exp_b[i]));
      end
    end
    chk("t1_fillSel", 64'(fillSel), 64'(1));
    chk("t1_fillDone", 64'(dut_fd - fd0), 64'(1));
    chk("t1_respErr", 64'(respErr), 64'(0));
    chk("t1_lastErr", 64'(lastErr), 64'(0));

    // Early rlast on beat 3 of 6.
    dut_addr.delete(); dut_bytes.delete(); fd0 = dut_fd;
    do_start(6, 0);
    run_burst(3, 0, 1'b0);
    do_swap(0);
    chk("t2_nwr", 64'(dut_addr.size()), 64'(3));
    for (int i = 0; i < dut_bytes.size(); i++) chk("t2_bytes", 64'(dut_bytes[i]), 64'(8));
    chk("t2_lastErr", 64'(lastErr), 64'(1));
    chk("t2_fillDone", 64'(dut_fd - fd0), 64'(1));
    chk("t2_fillSel", 64'(fillSel), 64'(0));

    // Missing rlast, then a 5-cycle swap stall.
    dut_addr.delete(); dut_bytes.delete();
    do_start(2, 0);
    run_burst(0, 0, 1'b0);
    chk("t3_busy", 64'(busy), 64'(1));
    chk("t3_lastErr", 64'(lastErr), 64'(1));
    drainEmpty = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_stall_fillSel", 64'(fillSel), 64'(0));
    end
    drainEmpty = 1'b1;
    tick();
    drainEmpty = 1'b0;
    chk("t3_swap_fillSel", 64'(fillSel), 64'(1));
    chk("t3_swap_busy", 64'(busy), 64'(0));
    chk("t3_nwr", 64'(dut_addr.size()), 64'(2));

    // Illegal beat counts.
    do_start(0, 0);
    chk("t4_cfgErr0", 64'(cfgErr), 64'(1));
    chk("t4_busy0", 64'(busy), 64'(0));
    tick();
    do_start(17, 0);
    chk("t4_cfgErr17", 64'(cfgErr), 64'(1));
    chk("t4_busy17", 64'(busy), 64'(0));
    tick();

    // Response error on beat 1, with random gaps.
    do_start(4, 0);
    run_burst(4, 1, 1'b1);
    chk("t5_respErr", 64'(respErr), 64'(1));
    chk("t5_lastErr", 64'(lastErr), 64'(0));
    do_swap(2);

    // Abort after the 2nd of 8 beats; a beat is also offered in the abort cycle.
    dut_addr.delete(); dut_bytes.delete(); fd0 = dut_fd;
    do_start(8, 0);
    guard = 0;
    while (m_taken < 2 && guard < 50) begin
      axi.rvalid = 1'b1;
      axi.rdata = {$urandom, $urandom};
      tick();
      guard++;
    end
    axi.rvalid = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    axi.rvalid = 1'b0;
    chk("t6_rready", 64'(axi.rready), 64'(0));
    chk("t6_busy", 64'(busy), 64'(0));
    repeat (3) tick();
    chk("t6_nwr", 64'(dut_addr.size()), 64'(3));
    chk("t6_fillDone", 64'(dut_fd - fd0), 64'(0));
    chk("t6_fillSel", 64'(fillSel), 64'(0));

    // Single-beat burst to leave fillSel at 1, then reset in the middle of a burst.
    do_start(1, 0);
    run_burst(1, 0, 1'b0);
    do_swap(0);
    chk("t7_pre_fillSel", 64'(fillSel), 64'(1));
    do_start(8, 0);
    for (int i = 0; i < 3; i++) begin
      axi.rvalid = 1'b1;
      tick();
    end
    chk_en = 1'b0;
    resetn = 1'b0;
    model_reset();
    #1;
    check_reset_vals("midrst");
    axi.rvalid = 1'b0;
    tick();
    resetn = 1'b1;
    chk_en = 1'b1;
    tick();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) beats = ($urandom_range(0, 1) == 0) ? BW'(0) : BW'($urandom_range(17, 31));
      else beats = BW'($urandom_range(1, CACHE_DEPTH));
      lastBytes  = CW'($urandom_range(0, CACHE_WIDTH));
      abort      = ($urandom_range(0, 99) == 0);
      drainEmpty = ($urandom_range(0, 2) != 0);
      axi.rvalid = ($urandom_range(0, 3) != 0);
      axi.rdata  = {$urandom, $urandom};
      axi.rresp  = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      if (m_state == 1 && m_taken + 1 == m_beats) axi.rlast = ($urandom_range(0, 7) != 0);
      else axi.rlast = ($urandom_range(0, 19) == 0);
      tick();
    end

    start = 1'b0; abort = 1'b0; drainEmpty = 1'b0;
    axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'd0;
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_fill_ctrl.md
CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 Parameters SHALL be:
- CACHE_WIDTH, default 8: AXI data bus width in bytes.
- CACHE_DEPTH, default 16: beats per cache.
- Derived widths: DW=CACHE_WIDTH*8, AW=clog2(CACHE_DEPTH-1), BW=clog2(CACHE_DEPTH)+1, CW=clog2(CACHE_WIDTH)+1.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle burst fill request.
- beats  in  BW  beats expected in the burst; valid range 1..CACHE_DEPTH.
- lastBytes  in  CW  valid bytes in the final beat; 0 means CACHE_WIDTH.
- abort  in  1  synchronous cancel.
- drainEmpty  in  1  the cache not currently being filled holds 0 bytes.
- rvalid  in  1  AXI R channel valid.
- rdata  in  DW  AXI R channel data.
- rresp  in  2  AXI R channel response.
- rlast  in  1  AXI R channel last.
- rready  out  1  AXI R channel ready.
- wrEn  out  1  cache write strobe.
- wrAddr  out  AW  cache write address.
- wrData  out  DW  cache write data.
- wrByteCnt  out  CW  bytes added by this write.
- fillSel  out  1  cache being filled (0/1); drives the cache's rdCacheSel.
- busy  out  1  state is not IDLE.
- fillDone  out  1  one-cycle pulse at burst completion.
- respErr  out  1  sticky-per-burst flag: any rresp!=0 seen; valid with fillDone.
- lastErr  out  1  rlast mismatch in the burst; valid with fillDone.
- cfgErr  out  1  one-cycle pulse when start carries an illegal beats value.

Function
REQ-003 The block SHALL use states IDLE, FILL, SWAP.
REQ-004 IDLE:
- rready=0.
- start with beats in 1..CACHE_DEPTH SHALL latch beats and lastBytes, clear the address counter, beat counter, respErr and lastErr, then go to FILL.
- start with beats=0 or beats>CACHE_DEPTH SHALL pulse cfgErr the next cycle and remain in IDLE.
REQ-005 start SHALL be ignored outside IDLE.
REQ-006 FILL:
- rready=1 combinationally.
- A handshake (rvalid&rready) SHALL produce, registered, on the next cycle: wrEn=1, wrData=rdata, wrAddr=current address, then increment the address.
REQ-007 wrByteCnt SHALL be CACHE_WIDTH on every beat except the final counted beat, which SHALL carry lastBytes (0 mapped to CACHE_WIDTH).
REQ-008 Any handshake with rresp!=0 SHALL set respErr; data SHALL still be written.
REQ-009 Burst end conditions:
- On the final counted beat, rlast=0 SHALL set lastErr.
- rlast=1 before the final counted beat SHALL set lastErr and end the burst immediately, with that beat written at CACHE_WIDTH bytes.
- In both cases the state SHALL go to SWAP after the beat.
REQ-010 SWAP:
- rready=0.
- Entry SHALL pulse fillDone once, with respErr and lastErr held stable until the next start.
- When drainEmpty=1, fillSel SHALL toggle and the state SHALL return to IDLE in the same cycle.
- Otherwise the block SHALL wait in SWAP.
REQ-011 abort SHALL move any state to IDLE on the next edge:
- rready drops immediately (combinational from state).
- No wrEn after the abort edge except a beat accepted in the abort cycle itself.
- fillSel unchanged; no fillDone pulse.
REQ-012 The address SHALL never exceed CACHE_DEPTH-1; the beat counter SHALL saturate rather than wrap.
REQ-013 Back-to-back handshakes SHALL sustain one write per cycle with no bubbles.

Reset
REQ-014 While resetn=0, the block SHALL be in IDLE with all registered outputs at the following values:
- rready=0, wrEn=0, wrAddr=0, wrData=0, wrByteCnt=0.
- fillSel=0, busy=0, fillDone=0, respErr=0, lastErr=0, cfgErr=0.
REQ-015 Reset asserted mid-burst SHALL discard the burst with no further wrEn and return fillSel to 0.

Verification (CACHE_WIDTH=8, CACHE_DEPTH=16)
REQ-016 Full burst:
- Stimulus: start, beats=4, lastBytes=3, 4 back-to-back beats with rlast on the 4th, drainEmpty=1.
- Response: wrEn on 4 consecutive cycles, wrAddr 0,1,2,3, wrByteCnt 8,8,8,3, fillDone pulse, fillSel 0->1, respErr=0, lastErr=0.
REQ-017 Early rlast:
- Stimulus: beats=6, rlast on the 3rd beat.
- Response: 3 writes at 8 bytes each, lastErr=1, fillDone.
REQ-018 Missing rlast:
- Stimulus: beats=2, rlast never asserted.
- Response: 2 writes at 8 bytes each, lastErr=1, state SWAP.
REQ-019 Swap stall:
- Stimulus: drainEmpty=0 for 5 cycles after the burst, then 1.
- Response: fillSel holds for 5 cycles, toggles on the cycle drainEmpty rises, busy falls.
REQ-020 Illegal start and response error:
- Stimulus: beats=0, then beats=17.
- Response: a cfgErr pulse for each, busy stays 0.
- Stimulus: a separate burst with rresp=2 on beat 1.
- Response: respErr=1 at fillDone.
REQ-021 Abort and reset mid-burst:
- Stimulus: abort after the 2nd of 8 beats.
- Response: rready=0 the same cycle, no fillDone, fillSel unchanged.
- Stimulus: resetn pulse mid-burst.
- Response: all outputs at reset values.
